// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a little-endian byte stream
// into 32-bit words, writes them from address 0 and releases the core when done.
module imem_loader #(
  parameter int IMEM_POWER = 18,
  parameter int WORD       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [IMEM_POWER-1:0] imem_addr,
  output logic [WORD-1:0]       imem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error,
  output logic [IMEM_POWER:0]   words_loaded
);

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_LAST  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam logic [32:0]           DEPTH    = 33'd1 << IMEM_POWER;
  localparam logic [IMEM_POWER-1:0] ADDR_ONE = {{(IMEM_POWER-1){1'b0}}, 1'b1};
  localparam logic [IMEM_POWER:0]   WL_ONE   = {{IMEM_POWER{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           asm_q, asm_d;
  logic [31:0]           n_q, n_d;
  logic [IMEM_POWER-1:0] addr_q, addr_d;
  logic [IMEM_POWER:0]   wl_q, wl_d;
  logic                  we_q, we_d;
  logic [WORD-1:0]       wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept_s;
  logic                  word_end_s;
  logic                  last_s;
  logic [WORD-1:0]       word_s;

  assign accept_s   = in_valid & ready_q;
  assign word_end_s = accept_s & (byte_idx_q == 2'd3);
  assign word_s     = {in_data, asm_q};
  // Word count only advances after the previous pulse, well before the next 4th byte.
  assign last_s     = ({{(32-IMEM_POWER){1'b0}}, wl_q} + 33'd1) == {1'b0, n_q};

  assign in_ready     = ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_hold    = hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = wl_q;

  // Next-state, byte assembly, counters and registered output decode.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    n_d        = n_q;
    addr_d     = addr_q;
    wl_d       = wl_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;

    if (we_q) begin
      addr_d = addr_q + ADDR_ONE;
      wl_d   = wl_q + WL_ONE;
    end else begin
      addr_d = addr_q;
      wl_d   = wl_q;
    end

    if (accept_s) begin
      byte_idx_d = byte_idx_q + 2'd1;
      case (byte_idx_q)
        2'd0:    asm_d[7:0]   = in_data;
        2'd1:    asm_d[15:8]  = in_data;
        2'd2:    asm_d[23:16] = in_data;
        default: asm_d        = asm_q;
      endcase
    end else begin
      byte_idx_d = byte_idx_q;
    end

    case (state_q)
      ST_LEN: begin
        if (word_end_s) begin
          n_d = word_s;
          if (word_s == 32'd0) begin
            state_d = ST_DONE;
          end else if ({1'b0, word_s} > DEPTH) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_DATA: begin
        if (word_end_s) begin
          we_d    = 1'b1;
          wdata_d = word_s;
          if (last_s) begin
            state_d = ST_LAST;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_LAST: state_d = ST_DONE;
      ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_LEN;
          byte_idx_d = 2'd0;
          asm_d      = 24'd0;
          addr_d     = '0;
          wl_d       = '0;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_LEN;
    endcase

    ready_d = (state_d == ST_LEN) || (state_d == ST_DATA);
    hold_d  = (state_d != ST_DONE);
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  // State and datapath registers; reset clears everything except memory contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LEN;
      byte_idx_q <= 2'd0;
      asm_q      <= 24'd0;
      n_q        <= 32'd0;
      addr_q     <= '0;
      wl_q       <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ready_q    <= 1'b1;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      wl_q       <= wl_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 16-word memory (IMEM_POWER=4).
module tb_imem_loader;
  localparam int P = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         imem_we;
  logic [P-1:0] imem_addr;
  logic [31:0]  imem_wdata;
  logic         core_hold;
  logic         done;
  logic         error;
  logic [P:0]   words_loaded;

  int total = 0;
  int bad   = 0;

  logic [P-1:0] wr_addr [0:31];
  logic [31:0]  wr_data [0:31];
  int           wr_cnt = 0;

  imem_loader #(.IMEM_POWER(P), .WORD(32)) dut (
    .clk(clk), .reset(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log: one entry per imem_we pulse.
  always @(negedge clk) begin
    if (imem_we === 1'b1 && wr_cnt < 32) begin
      wr_addr[wr_cnt] = imem_addr;
      wr_data[wr_cnt] = imem_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hxx;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL start_restart: hold=%b done=%b err=%b rdy=%b, want 1 0 0 1", core_hold, done, error, in_ready);
    end
    total++; if (words_loaded !== 5'd0) begin
      bad++; $display("FAIL start_clear_wl: got %0d want 0", words_loaded);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    idle(3);
    total++; if (imem_we !== 1'b0 || imem_addr !== 4'd0 || imem_wdata !== 32'd0) begin
      bad++; $display("FAIL reset_write: we=%b addr=%h data=%h, want 0 0 0", imem_we, imem_addr, imem_wdata);
    end
    total++; if (core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_status: hold=%b done=%b err=%b rdy=%b, want 1 0 0 1", core_hold, done, error, in_ready);
    end
    total++; if (words_loaded !== 5'd0) begin
      bad++; $display("FAIL reset_wl: got %0d want 0", words_loaded);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input bit gap);
    wr_cnt = 0;
    send_word(32'd2);
    send_word(32'h0000_0013);
    total++; if (imem_we !== 1'b1 || imem_addr !== 4'd0 || imem_wdata !== 32'h0000_0013) begin
      bad++; $display("FAIL basic_w0_pulse: we=%b addr=%h data=%h, want 1 0 00000013", imem_we, imem_addr, imem_wdata);
    end
    send_byte(8'h93);
    send_byte(8'h00);
    if (gap) begin
      idle(3);
      total++; if (in_ready !== 1'b1 || imem_we !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL gap_hold: rdy=%b we=%b done=%b, want 1 0 0", in_ready, imem_we, done);
      end
    end
    send_byte(8'h10);
    send_byte(8'h00);
    total++; if (imem_we !== 1'b1 || imem_addr !== 4'd1 || imem_wdata !== 32'h0010_0093) begin
      bad++; $display("FAIL basic_w1_pulse: we=%b addr=%h data=%h, want 1 1 00100093", imem_we, imem_addr, imem_wdata);
    end
    total++; if (done !== 1'b0 || in_ready !== 1'b0 || core_hold !== 1'b1) begin
      bad++; $display("FAIL basic_last_state: done=%b rdy=%b hold=%b, want 0 0 1", done, in_ready, core_hold);
    end
    @(negedge clk);
    total++; if (done !== 1'b1 || core_hold !== 1'b0 || imem_we !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL basic_done: done=%b hold=%b we=%b rdy=%b, want 1 0 0 0", done, core_hold, imem_we, in_ready);
    end
    total++; if (words_loaded !== 5'd2) begin
      bad++; $display("FAIL basic_wl: got %0d want 2", words_loaded);
    end
    @(negedge clk);
    total++; if (wr_cnt !== 2 || wr_addr[0] !== 4'd0 || wr_data[0] !== 32'h0000_0013 ||
                 wr_addr[1] !== 4'd1 || wr_data[1] !== 32'h0010_0093) begin
      bad++; $display("FAIL basic_log: cnt=%0d a0=%h d0=%h a1=%h d1=%h, want 2 0 00000013 1 00100093",
                      wr_cnt, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    pulse_start();
  endtask

  task automatic test_zero();
    wr_cnt = 0;
    send_word(32'd0);
    total++; if (done !== 1'b1 || core_hold !== 1'b0 || in_ready !== 1'b0 || words_loaded !== 5'd0) begin
      bad++; $display("FAIL zero_done: done=%b hold=%b rdy=%b wl=%0d, want 1 0 0 0", done, core_hold, in_ready, words_loaded);
    end
    idle(2);
    total++; if (wr_cnt !== 0) begin
      bad++; $display("FAIL zero_nowrite: got %0d writes want 0", wr_cnt);
    end
    pulse_start();
  endtask

  task automatic test_error();
    wr_cnt = 0;
    send_word(32'd17);
    total++; if (error !== 1'b1 || core_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL err_state: err=%b hold=%b rdy=%b done=%b, want 1 1 0 0", error, core_hold, in_ready, done);
    end
    idle(3);
    total++; if (wr_cnt !== 0 || error !== 1'b1) begin
      bad++; $display("FAIL err_sticky: writes=%0d err=%b, want 0 1", wr_cnt, error);
    end
    pulse_start();
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    total++; if (imem_we !== 1'b1 || imem_addr !== 4'd0 || imem_wdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL err_reload_pulse: we=%b addr=%h data=%h, want 1 0 deadbeef", imem_we, imem_addr, imem_wdata);
    end
    @(negedge clk);
    total++; if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 5'd1) begin
      bad++; $display("FAIL err_reload_done: done=%b err=%b wl=%0d, want 1 0 1", done, error, words_loaded);
    end
    @(negedge clk);
    total++; if (wr_cnt !== 1) begin
      bad++; $display("FAIL err_reload_cnt: got %0d writes want 1", wr_cnt);
    end
    pulse_start();
  endtask

  task automatic test_full();
    wr_cnt = 0;
    send_word(32'd16);
    for (int i = 0; i < 16; i++) send_word(32'h1000_0000 + i);
    total++; if (imem_we !== 1'b1 || imem_addr !== 4'd15 || imem_wdata !== 32'h1000_000F) begin
      bad++; $display("FAIL full_last_pulse: we=%b addr=%h data=%h, want 1 f 1000000f", imem_we, imem_addr, imem_wdata);
    end
    @(negedge clk);
    total++; if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 5'd16) begin
      bad++; $display("FAIL full_done: done=%b err=%b wl=%0d, want 1 0 16", done, error, words_loaded);
    end
    @(negedge clk);
    total++; if (wr_cnt !== 16) begin
      bad++; $display("FAIL full_cnt: got %0d writes want 16", wr_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      total++; if (wr_addr[i] !== i[3:0] || wr_data[i] !== 32'h1000_0000 + i) begin
        bad++; $display("FAIL full_word%0d: addr=%h data=%h, want %h %h", i, wr_addr[i], wr_data[i], i[3:0], 32'h1000_0000 + i);
      end
    end
  endtask

  task automatic test_midreset();
    pulse_start();
    send_word(32'd2);
    send_byte(8'hAA);
    total++; if (imem_wdata !== 32'h1000_000F) begin
      bad++; $display("FAIL midrst_pre: data=%h want 1000000f", imem_wdata);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem_we !== 1'b0 || imem_addr !== 4'd0 || imem_wdata !== 32'd0 || words_loaded !== 5'd0) begin
      bad++; $display("FAIL midrst_async: we=%b addr=%h data=%h wl=%0d, want 0 0 0 0", imem_we, imem_addr, imem_wdata, words_loaded);
    end
    total++; if (core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_status: hold=%b done=%b err=%b rdy=%b, want 1 0 0 1", core_hold, done, error, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_cnt = 0;
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    total++; if (imem_we !== 1'b1 || imem_addr !== 4'd0 || imem_wdata !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL midrst_reload: we=%b addr=%h data=%h, want 1 0 cafef00d", imem_we, imem_addr, imem_wdata);
    end
    @(negedge clk);
    total++; if (done !== 1'b1 || core_hold !== 1'b0 || words_loaded !== 5'd1) begin
      bad++; $display("FAIL midrst_done: done=%b hold=%b wl=%0d, want 1 0 1", done, core_hold, words_loaded);
    end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_zero();
    test_error();
    test_basic(1'b1);
    test_full();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
